// File: rtl/uart_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_serial_tx
// Brief    : UART transmitter, start + 8 data (LSB first) + optional parity
//            + 1/2 stop bits, one byte per SEND/READY handshake.
// Revision : 1.0 - initial release
// ============================================================================

module uart_serial_tx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx,
    output logic       tx_done
);

    localparam int              c_cnt_w     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_bit_last = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [2:0]      c_stop_last = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_clk_cnt;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_shift;
    logic                 r_parity;
    logic                 r_tx;
    logic                 r_ready;
    logic                 r_tx_done;

    logic                 w_parity;
    logic                 w_bit_end;

    generate
        if (PARITY_ODD != 0) begin : g_parity_odd
            assign w_parity = ~^data;
        end else begin : g_parity_even
            assign w_parity = ^data;
        end
    endgenerate

    assign w_bit_end = (r_clk_cnt == c_bit_last);

    // r_bit_idx counts data bits in S_DATA and stop bits in S_STOP.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
            r_ready   <= 1'b1;
            r_tx_done <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx      <= 1'b1;
                    r_ready   <= 1'b1;
                    r_clk_cnt <= '0;
                    r_bit_idx <= '0;
                    if (send) begin
                        r_shift  <= data;
                        r_parity <= w_parity;
                        r_tx     <= 1'b0;
                        r_ready  <= 1'b0;
                        r_state  <= S_START;
                    end
                end

                S_START: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + c_cnt_one;
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= '0;
                            if (PARITY_EN != 0) begin
                                r_tx    <= r_parity;
                                r_state <= S_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + c_cnt_one;
                    end
                end

                S_PARITY: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= 1'b1;
                        r_state   <= S_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + c_cnt_one;
                    end
                end

                S_STOP: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == c_stop_last) begin
                            r_bit_idx <= '0;
                            r_ready   <= 1'b1;
                            r_tx_done <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + c_cnt_one;
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_clk_cnt <= '0;
                    r_bit_idx <= '0;
                    r_tx      <= 1'b1;
                    r_ready   <= 1'b1;
                end
            endcase
        end
    end

    assign ready   = r_ready;
    assign tx      = r_tx;
    assign tx_done = r_tx_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_serial_tx
// Brief    : Directed bench for uart_serial_tx over five parameter sets.
// Revision : 1.0 - initial release
// ============================================================================

module tb_uart_serial_tx;

    localparam int N_DUT = 5;
    localparam int CPB   [N_DUT] = '{4, 4, 4, 4, 2};
    localparam int PEN   [N_DUT] = '{0, 1, 1, 1, 0};
    localparam int PODD  [N_DUT] = '{0, 0, 1, 0, 0};
    localparam int STOPS [N_DUT] = '{1, 1, 1, 2, 1};

    logic       clk = 1'b0;
    logic       rst;
    logic       send  [N_DUT];
    logic [7:0] din   [N_DUT];
    logic       ready [N_DUT];
    logic       tx    [N_DUT];
    logic       done  [N_DUT];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] seen;

    always #5 clk = ~clk;

    uart_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .reset(rst), .send(send[0]), .data(din[0]),
        .ready(ready[0]), .tx(tx[0]), .tx_done(done[0]));
    uart_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .reset(rst), .send(send[1]), .data(din[1]),
        .ready(ready[1]), .tx(tx[1]), .tx_done(done[1]));
    uart_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .reset(rst), .send(send[2]), .data(din[2]),
        .ready(ready[2]), .tx(tx[2]), .tx_done(done[2]));
    uart_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_8e2 (
        .clk(clk), .reset(rst), .send(send[3]), .data(din[3]),
        .ready(ready[3]), .tx(tx[3]), .tx_done(done[3]));
    uart_serial_tx #(.CLKS_PER_BIT(2), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_fast (
        .clk(clk), .reset(rst), .send(send[4]), .data(din[4]),
        .ready(ready[4]), .tx(tx[4]), .tx_done(done[4]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Serial bit b of a frame for instance k: start, data LSB first, parity, stops.
    function automatic logic frame_bit(input int k, input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (PEN[k] != 0 && b == 9) return (PODD[k] != 0) ? ~^d : ^d;
        return 1'b1;
    endfunction

    // Called just after a rising edge; the next edge is the accepting edge.
    task automatic frame(input int k, input logic [7:0] d, input bit hold, input bit disturb,
                         output logic [15:0] bits);
        int c;
        int f;
        c    = CPB[k];
        f    = (1 + 8 + PEN[k] + STOPS[k]) * c;
        bits = '0;
        send[k] = 1'b1;
        din[k]  = d;
        for (int j = 0; j < f; j++) begin
            @(posedge clk); #1;
            if (j == 0 && !hold) send[k] = 1'b0;
            if (disturb && j == 3 * c) begin
                din[k]  = 8'h00;
                send[k] = 1'b1;
            end
            if (disturb && j == 3 * c + 2) send[k] = 1'b0;
            check("tx_bit", tx[k], frame_bit(k, d, j / c));
            check("ready_busy", ready[k], 1'b0);
            check("done_busy", done[k], 1'b0);
            if (j % c == c / 2) bits[j / c] = tx[k];
        end
        @(posedge clk); #1;
        check("ready_end", ready[k], 1'b1);
        check("done_pulse", done[k], 1'b1);
        check("tx_end", tx[k], 1'b1);
        check("loopback", bits[8:1], d);
    endtask

    task automatic idle(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check("idle_tx", tx[k], 1'b1);
            check("idle_ready", ready[k], 1'b1);
            check("idle_done", done[k], 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        for (int k = 0; k < N_DUT; k++) begin
            send[k] = 1'b0;
            din[k]  = 8'h00;
        end

        // Reset held three cycles, then quiet line
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < N_DUT; k++) begin
            check("rst_tx", tx[k], 1'b1);
            check("rst_ready", ready[k], 1'b1);
            check("rst_done", done[k], 1'b0);
        end
        rst = 1'b0;
        idle(0, 50);

        // 8N1 A5: line 0,1,0,1,0,0,1,0,1,1
        frame(0, 8'hA5, 1'b0, 1'b0, seen);
        check("a5_bits", seen[9:0], 10'h34A);
        idle(0, 3);

        // Parity variants with 07
        frame(1, 8'h07, 1'b0, 1'b0, seen);
        check("even_bits", seen[10:0], 11'h60E);
        check("even_parity", seen[9], 1'b1);
        idle(1, 2);
        frame(2, 8'h07, 1'b0, 1'b0, seen);
        check("odd_bits", seen[10:0], 11'h40E);
        check("odd_parity", seen[9], 1'b0);
        idle(2, 2);
        frame(3, 8'h07, 1'b0, 1'b0, seen);
        check("two_stop_bits", seen[11:0], 12'hE0E);
        idle(3, 2);

        // SEND held high: back-to-back every 41 cycles
        frame(0, 8'hDE, 1'b1, 1'b0, seen);
        check("de_bits_1", seen[9:0], 10'h3BC);
        frame(0, 8'hDE, 1'b1, 1'b0, seen);
        check("de_bits_2", seen[9:0], 10'h3BC);
        frame(0, 8'hDE, 1'b0, 1'b0, seen);
        check("de_bits_3", seen[9:0], 10'h3BC);
        idle(0, 3);

        // DATA change and SEND re-pulse mid-frame are ignored
        frame(0, 8'hDE, 1'b0, 1'b1, seen);
        check("de_disturbed", seen[9:0], 10'h3BC);
        idle(0, 45);

        // Reset mid-frame aborts without TX_DONE
        send[0] = 1'b1;
        din[0]  = 8'h3C;
        @(posedge clk); #1;
        send[0] = 1'b0;
        check("abort_started", tx[0], 1'b0);
        repeat (17) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_tx", tx[0], 1'b1);
        check("abort_ready", ready[0], 1'b1);
        check("abort_done", done[0], 1'b0);
        rst = 1'b0;
        idle(0, 45);
        frame(0, 8'h3C, 1'b0, 1'b0, seen);
        check("3c_bits", seen[9:0], 10'h278);
        idle(0, 3);

        // Two-cycle bits, FF then 00 back-to-back
        frame(4, 8'hFF, 1'b1, 1'b0, seen);
        check("ff_bits", seen[9:0], 10'h3FE);
        frame(4, 8'h00, 1'b0, 1'b0, seen);
        check("00_bits", seen[9:0], 10'h200);
        idle(4, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
